// File: rtl/multiphase_clock_gen_if.sv
// Control and phase-output bundle for the multiphase clock generator.
// The master side drives en/step; the slave side (generator) returns outputs.
interface multiphase_clock_gen_if #(
  parameter int NSTAGE = 2,
  parameter int STEP_W = 8
);
  logic              en;
  logic [STEP_W-1:0] step;
  logic [NSTAGE-1:0] phase;
  logic              sync;
  logic              running;

  modport master (
    output en,
    output step,
    input  phase,
    input  sync,
    input  running
  );

  modport slave (
    input  en,
    input  step,
    output phase,
    output sync,
    output running
  );
endinterface

// File: rtl/multiphase_clock_gen.sv
// Johnson-counter multiphase clock generator with prescaler.
// Step and stop requests only take effect at period wrap.
module multiphase_clock_gen #(
  parameter int NSTAGE = 2,
  parameter int STEP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  multiphase_clock_gen_if.slave  bus
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [NSTAGE-1:0] J_LAST =
    {1'b1, {(NSTAGE-1){1'b0}}};

  state_t            state_q, state_d;
  logic [NSTAGE-1:0] j_q, j_d;
  logic [STEP_W-1:0] pc_q, pc_d;
  logic [STEP_W-1:0] sreg_q, sreg_d;
  logic              sync_q, sync_d;
  logic              run_q, run_d;

  logic [STEP_W-1:0] step_eff;
  logic [NSTAGE-1:0] j_adv;
  logic              adv;

  // A zero step would never advance; treat it as one.
  assign step_eff = (bus.step == '0) ? STEP_W'(1) : bus.step;
  assign j_adv    = {j_q[NSTAGE-2:0], ~j_q[NSTAGE-1]};
  assign adv      = (pc_q == sreg_q - STEP_W'(1));

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    pc_d    = pc_q;
    sreg_d  = sreg_q;
    run_d   = run_q;
    sync_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = RUN;
          run_d   = 1'b1;
          j_d     = '0;
          pc_d    = '0;
          sreg_d  = step_eff;
          sync_d  = 1'b1;
        end
      end
      RUN: begin
        if (!adv) begin
          pc_d = pc_q + STEP_W'(1);
        end else begin
          pc_d = '0;
          j_d  = j_adv;
          if (j_q == J_LAST) begin
            if (bus.en) begin
              sreg_d = step_eff;
              sync_d = 1'b1;
            end else begin
              state_d = IDLE;
              run_d   = 1'b0;
              j_d     = '0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        run_d   = 1'b0;
        j_d     = '0;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      pc_q    <= '0;
      sreg_q  <= STEP_W'(1);
      sync_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      pc_q    <= pc_d;
      sreg_q  <= sreg_d;
      sync_q  <= sync_d;
      run_q   <= run_d;
    end
  end

  assign bus.phase   = j_q;
  assign bus.sync    = sync_q;
  assign bus.running = run_q;

endmodule

// File: tb/tb_multiphase_clock_gen.sv
// Bench for multiphase_clock_gen: NSTAGE=2 and NSTAGE=4 instances
// checked every cycle against a period/time-based reference model.
module tb_multiphase_clock_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] step = 8'd1;

  always #5 clk = ~clk;

  multiphase_clock_gen_if #(.NSTAGE(2), .STEP_W(8)) bus2 ();
  multiphase_clock_gen_if #(.NSTAGE(4), .STEP_W(8)) bus4 ();

  assign bus2.en   = en;
  assign bus2.step = step;
  assign bus4.en   = en;
  assign bus4.step = step;

  multiphase_clock_gen #(.NSTAGE(2), .STEP_W(8)) u2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  multiphase_clock_gen #(.NSTAGE(4), .STEP_W(8)) u4 (
    .clk(clk),
    .rst(rst),
    .bus(bus4)
  );

  logic [5:0] o2, o4;
  assign o2 = {bus2.running, bus2.sync, 2'b00, bus2.phase};
  assign o4 = {bus4.running, bus4.sync, bus4.phase};

  int total = 0;
  int bad = 0;

  // Model: time t within the current period, current step s.
  int m_run  [2] = '{0, 0};
  int m_t    [2] = '{0, 0};
  int m_s    [2] = '{1, 1};
  int m_sync [2] = '{0, 0};

  function automatic void model_edge(int idx);
    int n;
    int se;
    n  = (idx == 0) ? 2 : 4;
    se = (step == 8'd0) ? 1 : int'(step);
    if (rst) begin
      m_run[idx] = 0; m_t[idx] = 0;
      m_s[idx] = 1; m_sync[idx] = 0;
    end else if (m_run[idx] == 0) begin
      m_sync[idx] = 0;
      if (en) begin
        m_run[idx] = 1; m_t[idx] = 0;
        m_s[idx] = se; m_sync[idx] = 1;
      end
    end else begin
      m_t[idx]++;
      m_sync[idx] = 0;
      if (m_t[idx] == 2 * n * m_s[idx]) begin
        m_t[idx] = 0;
        if (en) begin
          m_s[idx] = se;
          m_sync[idx] = 1;
        end else begin
          m_run[idx] = 0;
        end
      end
    end
  endfunction

  // Bit i is high for Johnson index k with i < k <= i+n.
  function automatic logic [5:0] exp_o(int idx);
    int n;
    int k;
    logic [3:0] ph;
    n  = (idx == 0) ? 2 : 4;
    ph = 4'd0;
    if (m_run[idx] != 0) begin
      k = m_t[idx] / m_s[idx];
      for (int i = 0; i < n; i++)
        if (i < k && k <= i + n) ph[i] = 1'b1;
    end
    return {m_run[idx] != 0, m_sync[idx] != 0, ph};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    step = 8'($urandom);
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (o2 !== 6'd0 || o4 !== 6'd0) begin
        bad++;
        $display("FAIL reset c=%0d got2=%b got4=%b want=0",
                 c, o2, o4);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [1:0] seq2 [4];
    seq2 = '{2'd0, 2'd1, 2'd3, 2'd2};
    do_reset();
    en = 1'b1;
    step = 8'd1;
    for (int c = 0; c < 16; c++) begin
      tick();
      total++;
      if (o2 !== exp_o(0)) begin
        bad++;
        $display("FAIL basic_n2 c=%0d got=%b want=%b",
                 c, o2, exp_o(0));
      end
      total++;
      if (o4 !== exp_o(1)) begin
        bad++;
        $display("FAIL basic_n4 c=%0d got=%b want=%b",
                 c, o4, exp_o(1));
      end
      total++;
      if (bus2.phase !== seq2[c % 4] ||
          bus2.sync !== (c % 4 == 0) ||
          bus2.running !== 1'b1) begin
        bad++;
        $display("FAIL basic_seq c=%0d got=%b want=1%b00%b",
                 c, o2, (c % 4 == 0), seq2[c % 4]);
      end
    end
  endtask

  task automatic test_n4_step3();
    logic [3:0] seq4 [8];
    seq4 = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hf, 4'he, 4'hc, 4'h8};
    do_reset();
    en = 1'b1;
    step = 8'd3;
    for (int c = 0; c < 48; c++) begin
      tick();
      total++;
      if (o4 !== exp_o(1)) begin
        bad++;
        $display("FAIL n4_step3 c=%0d got=%b want=%b",
                 c, o4, exp_o(1));
      end
      total++;
      if (bus4.phase !== seq4[(c / 3) % 8] ||
          bus4.sync !== (c % 24 == 0)) begin
        bad++;
        $display("FAIL n4_seq c=%0d got=%b/%b want=%b/%b",
                 c, bus4.phase, bus4.sync,
                 seq4[(c / 3) % 8], (c % 24 == 0));
      end
    end
  endtask

  task automatic test_step_change();
    int syncs [$];
    bit changed;
    changed = 1'b0;
    do_reset();
    en = 1'b1;
    step = 8'd3;
    for (int c = 0; c < 40; c++) begin
      tick();
      total++;
      if (o2 !== exp_o(0) || o4 !== exp_o(1)) begin
        bad++;
        $display("FAIL step_change c=%0d got=%b/%b want=%b/%b",
                 c, o2, o4, exp_o(0), exp_o(1));
      end
      if (bus2.sync === 1'b1) syncs.push_back(c);
      if (!changed && bus2.phase === 2'b01) begin
        step = 8'd2;
        changed = 1'b1;
      end
    end
    total++;
    if (syncs.size() < 3) begin
      bad++;
      $display("FAIL step_spacing count got=%0d want>=3",
               syncs.size());
    end else if (syncs[1] - syncs[0] != 12 ||
                 syncs[2] - syncs[1] != 8) begin
      bad++;
      $display("FAIL step_spacing got=%0d,%0d want=12,8",
               syncs[1] - syncs[0], syncs[2] - syncs[1]);
    end
  endtask

  task automatic test_stop();
    logic [1:0] tail [4];
    bit found;
    tail = '{2'd3, 2'd2, 2'd2, 2'd0};
    found = 1'b0;
    do_reset();
    en = 1'b1;
    step = 8'd2;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (bus2.phase === 2'b11) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL stop_wait got=timeout want=phase11");
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({bus2.running, bus2.sync, bus2.phase} !==
          {i < 3, 1'b0, tail[i]}) begin
        bad++;
        $display("FAIL stop_tail i=%0d got=%b want=%b0%b",
                 i, {bus2.running, bus2.sync, bus2.phase},
                 (i < 3), tail[i]);
      end
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (o2 !== 6'd0 || o4 !== exp_o(1)) begin
        bad++;
        $display("FAIL stop_hold c=%0d got=%b/%b want=0/%b",
                 c, o2, o4, exp_o(1));
      end
    end
  endtask

  task automatic test_step0_reset();
    logic [1:0] seq2 [4];
    bit found;
    seq2 = '{2'd0, 2'd1, 2'd3, 2'd2};
    found = 1'b0;
    do_reset();
    en = 1'b1;
    step = 8'd0;
    for (int c = 0; c < 12; c++) begin
      tick();
      total++;
      if (o2 !== exp_o(0) || o4 !== exp_o(1) ||
          bus2.sync !== (c % 4 == 0) ||
          bus2.phase !== seq2[c % 4]) begin
        bad++;
        $display("FAIL step0 c=%0d got=%b/%b want=%b/%b",
                 c, o2, o4, exp_o(0), exp_o(1));
      end
    end
    for (int c = 0; c < 8 && !found; c++) begin
      if (bus2.phase === 2'b11) found = 1'b1;
      else tick();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL rst_wait got=timeout want=phase11");
    end
    rst = 1'b1;
    tick();
    total++;
    if (o2 !== 6'd0 || o4 !== 6'd0) begin
      bad++;
      $display("FAIL rst_mid got=%b/%b want=0/0", o2, o4);
    end
    rst = 1'b0;
  endtask

  task automatic test_cancel();
    int s;
    int p;
    s = int'($urandom_range(1, 3));
    p = 4 * s;
    do_reset();
    step = 8'(s);
    for (int c = 0; c < 8 * p; c++) begin
      en = !((c % p) == 1 || (c % p) == 2);
      tick();
      total++;
      if (o2 !== exp_o(0) || o4 !== exp_o(1) ||
          bus2.running !== 1'b1 || bus4.running !== 1'b1 ||
          bus2.sync !== (c % p == 0)) begin
        bad++;
        $display("FAIL cancel s=%0d c=%0d got=%b/%b want=%b/%b",
                 s, c, o2, o4, exp_o(0), exp_o(1));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0)
        step = 8'($urandom_range(0, 4));
      tick();
      total++;
      if (o2 !== exp_o(0)) begin
        bad++;
        $display("FAIL random_n2 c=%0d got=%b want=%b",
                 c, o2, exp_o(0));
      end
      total++;
      if (o4 !== exp_o(1)) begin
        bad++;
        $display("FAIL random_n4 c=%0d got=%b want=%b",
                 c, o4, exp_o(1));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_n4_step3();
    test_step_change();
    test_stop();
    test_step0_reset();
    test_cancel();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
